// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - streams NTAP coefficients into the FIR coefficient RAM.
// Optional burst checksum accumulator is built only when COEFF_LOADER_CHECKSUM_EN is defined.
module fir_coeff_loader #(
  parameter int DWIDTH = 16,
  parameter int NTAP   = 33,
  parameter int AWIDTH = 6
) (
  input  logic                            iClk_12M,
  input  logic                            iRsn,
  input  logic                            iStart,
  input  logic                            iCoeffValid,
  input  logic signed [DWIDTH-1:0]        iCoeffData,
  output logic                            oCoeffReady,
  output logic                            oCoeffiUpdateFlag,
  output logic                            oCsnRam,
  output logic                            oWrnRam,
  output logic [AWIDTH-1:0]               oAddrRam,
  output logic signed [DWIDTH-1:0]        oWrDtRam,
  output logic                            oBusy,
  output logic                            oDone,
  output logic signed [DWIDTH+AWIDTH-1:0] oChecksum
);

  // One extra bit so the counter can reach NTAP even when NTAP == 2^AWIDTH.
  localparam int CWIDTH = AWIDTH + 1;
  localparam logic [CWIDTH-1:0] NTAP_C = CWIDTH'(NTAP);
  localparam logic [CWIDTH-1:0] LAST_C = CWIDTH'(NTAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    DRAIN,
    TAIL
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [CWIDTH-1:0] beatCnt;
  logic              handshake;

  always_comb begin
    oCoeffReady = (state == LOAD) && (beatCnt < NTAP_C);
    handshake   = iCoeffValid && oCoeffReady;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = SETUP;
      SETUP:   nextState = LOAD;
      LOAD:    if (handshake && (beatCnt == LAST_C)) nextState = DRAIN;
      DRAIN:   nextState = TAIL;
      TAIL:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRsn) begin
      state   <= IDLE;
      beatCnt <= '0;
    end else begin
      state <= nextState;
      if (state == SETUP) begin
        beatCnt <= '0;
      end else if (handshake) begin
        beatCnt <= beatCnt + CWIDTH'(1);
      end
    end
  end

  // Status outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge iClk_12M) begin
    if (iRsn) begin
      oCsnRam           <= 1'b1;
      oWrnRam           <= 1'b1;
      oAddrRam          <= '0;
      oWrDtRam          <= '0;
      oCoeffiUpdateFlag <= 1'b0;
      oBusy             <= 1'b0;
      oDone             <= 1'b0;
    end else begin
      oCsnRam           <= ~handshake;
      oWrnRam           <= ~handshake;
      oCoeffiUpdateFlag <= (nextState != IDLE);
      oBusy             <= (nextState != IDLE);
      oDone             <= (nextState == TAIL);
      if (handshake) begin
        oAddrRam <= beatCnt[AWIDTH-1:0];
        oWrDtRam <= iCoeffData;
      end
    end
  end

`ifdef COEFF_LOADER_CHECKSUM_EN
  always_ff @(posedge iClk_12M) begin
    if (iRsn) begin
      oChecksum <= '0;
    end else if (nextState == SETUP) begin
      oChecksum <= '0;
    end else if (handshake) begin
      oChecksum <= oChecksum + {{AWIDTH{iCoeffData[DWIDTH-1]}}, iCoeffData};
    end
  end
`else
  assign oChecksum = '0;
`endif

endmodule
